// File: rtl/mem_io_responder.sv
// Data-memory port responder: routes CPU loads/stores to the dmem BRAM (addr[31]=0)
// or to MMIO registers (UART TX/RX, cycle and retired-instruction counters).
module mem_io_responder #(
    parameter int DMEM_AW = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    input  logic [3:0]         req_we,
    input  logic [31:0]        req_addr,
    input  logic [31:0]        req_wdata,
    output logic               rsp_valid,
    output logic [31:0]        rsp_rdata,
    output logic               dmem_en,
    output logic [3:0]         dmem_we,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [31:0]        dmem_din,
    input  logic [31:0]        dmem_dout,
    output logic [7:0]         uart_tx_data,
    output logic               uart_tx_valid,
    input  logic               uart_tx_ready,
    input  logic [7:0]         uart_rx_data,
    input  logic               uart_rx_valid,
    output logic               uart_rx_ready,
    input  logic               inst_retired
);

    localparam logic [5:0] OFF_STATUS = 6'h00;
    localparam logic [5:0] OFF_RXDATA = 6'h01;
    localparam logic [5:0] OFF_TXDATA = 6'h02;
    localparam logic [5:0] OFF_CYCLE  = 6'h04;
    localparam logic [5:0] OFF_INST   = 6'h05;
    localparam logic [5:0] OFF_CLEAR  = 6'h06;

    logic        rsp_valid_q,   rsp_valid_d;
    logic        rsp_dmem_q,    rsp_dmem_d;
    logic [31:0] mmio_rdata_q,  mmio_rdata_d;
    logic [7:0]  tx_data_q,     tx_data_d;
    logic        tx_valid_q,    tx_valid_d;
    logic        tx_overflow_q, tx_overflow_d;
    logic [7:0]  rx_byte_q,     rx_byte_d;
    logic        rx_full_q,     rx_full_d;
    logic [31:0] cycle_cnt_q,   cycle_cnt_d;
    logic [31:0] inst_cnt_q,    inst_cnt_d;

    logic       rd_s;
    logic       wr_s;
    logic       mmio_s;
    logic [5:0] off_s;
    logic       tx_wr_s;
    logic       tx_accept_s;
    logic       rx_pop_s;
    logic       rx_push_s;
    logic       clear_s;
    logic       unused_s;

    assign unused_s = ^{req_addr[30:8], req_addr[1:0]};

    // Request decode and BRAM pass-through
    always_comb begin
        rd_s        = req_valid && (req_we == 4'h0);
        wr_s        = req_valid && (req_we != 4'h0);
        mmio_s      = req_addr[31];
        off_s       = req_addr[7:2];
        tx_wr_s     = wr_s && mmio_s && (off_s == OFF_TXDATA);
        clear_s     = wr_s && mmio_s && (off_s == OFF_CLEAR);
        rx_pop_s    = rd_s && mmio_s && (off_s == OFF_RXDATA) && rx_full_q;
        rx_push_s   = uart_rx_valid && !rx_full_q;
        tx_accept_s = tx_valid_q && uart_tx_ready;
        dmem_en     = req_valid && !mmio_s;
        dmem_we     = dmem_en ? req_we : 4'h0;
        dmem_addr   = req_addr[DMEM_AW+1:2];
        dmem_din    = req_wdata;
    end

    // Next-state for response path, UART buffers and counters
    always_comb begin
        rsp_valid_d   = rd_s;
        rsp_dmem_d    = rd_s && !mmio_s;
        mmio_rdata_d  = 32'h0;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        tx_overflow_d = tx_overflow_q;
        rx_byte_d     = rx_byte_q;
        rx_full_d     = rx_full_q;

        // MMIO read data always reflects state before this cycle's update
        if (rd_s && mmio_s) begin
            case (off_s)
                OFF_STATUS: mmio_rdata_d = {29'h0, tx_overflow_q, rx_full_q, !tx_valid_q};
                OFF_RXDATA: mmio_rdata_d = {24'h0, rx_byte_q};
                OFF_CYCLE:  mmio_rdata_d = cycle_cnt_q;
                OFF_INST:   mmio_rdata_d = inst_cnt_q;
                default:    mmio_rdata_d = 32'h0;
            endcase
        end else begin
            mmio_rdata_d = 32'h0;
        end

        if (tx_accept_s) begin
            tx_valid_d = 1'b0;
        end else begin
            tx_valid_d = tx_valid_q;
        end

        // A byte arriving while the holding register is still occupied is lost
        if (tx_wr_s && (!tx_valid_q || tx_accept_s)) begin
            tx_data_d  = req_wdata[7:0];
            tx_valid_d = 1'b1;
        end else if (tx_wr_s) begin
            tx_overflow_d = 1'b1;
        end else begin
            tx_data_d = tx_data_q;
        end

        if (rx_pop_s) begin
            rx_full_d = 1'b0;
        end else if (rx_push_s) begin
            rx_full_d = 1'b1;
            rx_byte_d = uart_rx_data;
        end else begin
            rx_full_d = rx_full_q;
        end

        if (clear_s) begin
            cycle_cnt_d   = 32'h0;
            inst_cnt_d    = 32'h0;
            tx_overflow_d = 1'b0;
        end else begin
            cycle_cnt_d = cycle_cnt_q + 32'd1;
            inst_cnt_d  = inst_cnt_q + {31'h0, inst_retired};
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q   <= 1'b0;
            rsp_dmem_q    <= 1'b0;
            mmio_rdata_q  <= 32'h0;
            tx_data_q     <= 8'h0;
            tx_valid_q    <= 1'b0;
            tx_overflow_q <= 1'b0;
            rx_byte_q     <= 8'h0;
            rx_full_q     <= 1'b0;
            cycle_cnt_q   <= 32'h0;
            inst_cnt_q    <= 32'h0;
        end else begin
            rsp_valid_q   <= rsp_valid_d;
            rsp_dmem_q    <= rsp_dmem_d;
            mmio_rdata_q  <= mmio_rdata_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            tx_overflow_q <= tx_overflow_d;
            rx_byte_q     <= rx_byte_d;
            rx_full_q     <= rx_full_d;
            cycle_cnt_q   <= cycle_cnt_d;
            inst_cnt_q    <= inst_cnt_d;
        end
    end

    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_dmem_q ? dmem_dout : mmio_rdata_q;
    assign uart_tx_data  = tx_data_q;
    assign uart_tx_valid = tx_valid_q;
    assign uart_rx_ready = !rx_full_q;

endmodule

// File: tb/tb_mem_io_responder.sv
// Bench for mem_io_responder: directed scenarios plus random traffic, all checked
// against a transaction-level model of the memory map, UART buffers and counters.
module tb_mem_io_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [3:0]  req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        dmem_en;
    logic [3:0]  dmem_we;
    logic [11:0] dmem_addr;
    logic [31:0] dmem_din;
    logic [31:0] dmem_dout;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic        inst_retired;

    mem_io_responder #(.DMEM_AW(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
        .dmem_dout(dmem_dout),
        .uart_tx_data(uart_tx_data), .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
        .uart_rx_data(uart_rx_data), .uart_rx_valid(uart_rx_valid), .uart_rx_ready(uart_rx_ready),
        .inst_retired(inst_retired)
    );

    always #5 clk = ~clk;

    // Stand-in BRAM: registered read, byte-enabled write
    logic [31:0] bram [0:4095];
    initial begin
        for (int i = 0; i < 4096; i++) bram[i] = 32'h0;
        dmem_dout = 32'h0;
    end
    always @(posedge clk) begin
        if (dmem_en) begin
            for (int b = 0; b < 4; b++)
                if (dmem_we[b]) bram[dmem_addr][8*b +: 8] <= dmem_din[8*b +: 8];
            dmem_dout <= bram[dmem_addr];
        end
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [31:0] m_mem [0:4095];
    logic        m_rv;
    logic [31:0] m_rd;
    logic        m_chk_rd;
    logic [7:0]  m_txd;
    logic        m_txv;
    logic        m_ovf;
    logic [7:0]  m_rxb;
    logic        m_rxf;
    logic [31:0] m_cyc;
    logic [31:0] m_inst;

    // Environment drive values held across steps
    logic       g_rst = 1'b1;
    logic       g_txr = 1'b0;
    logic       g_rxv = 1'b0;
    logic [7:0] g_rxd = 8'h0;
    logic       g_ir  = 1'b0;

    task automatic model_reset();
        m_rv = 1'b0; m_rd = 32'h0; m_chk_rd = 1'b1;
        m_txd = 8'h0; m_txv = 1'b0; m_ovf = 1'b0;
        m_rxb = 8'h0; m_rxf = 1'b0; m_cyc = 32'h0; m_inst = 32'h0;
    endtask

    // One clock cycle: drive, check, advance the model, move to the next falling edge
    task automatic step(input logic v, input logic [3:0] we, input logic [31:0] a, input logic [31:0] wd);
        logic        rd, wr, mm, clr, acc;
        logic [7:0]  off;
        logic [11:0] wa;
        rst_n = g_rst; req_valid = v; req_we = we; req_addr = a; req_wdata = wd;
        uart_tx_ready = g_txr; uart_rx_valid = g_rxv; uart_rx_data = g_rxd; inst_retired = g_ir;
        #1;
        chk("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_rv});
        if (m_chk_rd) chk("rsp_rdata", rsp_rdata, m_rd);
        chk("tx_valid", {31'h0, uart_tx_valid}, {31'h0, m_txv});
        chk("tx_data", {24'h0, uart_tx_data}, {24'h0, m_txd});
        chk("rx_ready", {31'h0, uart_rx_ready}, {31'h0, !m_rxf});
        chk("dmem_en", {31'h0, dmem_en}, {31'h0, v && !a[31]});
        chk("dmem_we", {28'h0, dmem_we}, (v && !a[31]) ? {28'h0, we} : 32'h0);
        chk("dmem_addr", {20'h0, dmem_addr}, {20'h0, a[13:2]});
        chk("dmem_din", dmem_din, wd);

        rd  = v && (we == 4'h0);
        wr  = v && (we != 4'h0);
        mm  = a[31];
        off = {a[7:2], 2'b00};
        wa  = a[13:2];
        if (wr && !mm)
            for (int b = 0; b < 4; b++)
                if (we[b]) m_mem[wa][8*b +: 8] = wd[8*b +: 8];
        if (!g_rst) begin
            model_reset();
        end else begin
            m_rv = rd; m_chk_rd = rd; m_rd = 32'h0;
            if (rd && !mm) m_rd = m_mem[wa];
            if (rd && mm) begin
                if (off == 8'h00) m_rd = {29'h0, m_ovf, m_rxf, !m_txv};
                else if (off == 8'h04) m_rd = {24'h0, m_rxb};
                else if (off == 8'h10) m_rd = m_cyc;
                else if (off == 8'h14) m_rd = m_inst;
            end
            acc = m_txv && g_txr;
            if (acc) m_txv = 1'b0;
            if (wr && mm && off == 8'h08) begin
                if (m_txv && !acc) m_ovf = 1'b1;
                else begin m_txd = wd[7:0]; m_txv = 1'b1; end
            end
            if (rd && mm && off == 8'h04 && m_rxf) m_rxf = 1'b0;
            else if (g_rxv && !m_rxf) begin m_rxf = 1'b1; m_rxb = g_rxd; end
            clr = wr && mm && off == 8'h18;
            m_cyc  = clr ? 32'h0 : m_cyc + 32'd1;
            m_inst = clr ? 32'h0 : m_inst + (g_ir ? 32'd1 : 32'd0);
            if (clr) m_ovf = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 32'h0, 32'h0);
    endtask
    task automatic rd(input logic [31:0] a);
        step(1'b1, 4'h0, a, 32'h0);
    endtask
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, 4'hF, a, d);
    endtask
    task automatic do_reset();
        g_rst = 1'b0; idle(1); g_rst = 1'b1;
    endtask

    logic [31:0] mm_offs [0:8];
    logic [31:0] a;
    logic [3:0]  we;
    int          kind;

    initial begin
        for (int i = 0; i < 4096; i++) m_mem[i] = 32'h0;
        mm_offs[0] = 32'h00; mm_offs[1] = 32'h04; mm_offs[2] = 32'h08;
        mm_offs[3] = 32'h0C; mm_offs[4] = 32'h10; mm_offs[5] = 32'h14;
        mm_offs[6] = 32'h18; mm_offs[7] = 32'h20; mm_offs[8] = 32'h3C;
        rst_n = 1'b0; req_valid = 1'b0; req_we = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
        uart_tx_ready = 1'b0; uart_rx_valid = 1'b0; uart_rx_data = 8'h0; inst_retired = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_reset();
        g_rst = 1'b1;

        // dmem store then load
        wr(32'h0000_0100, 32'hDEAD_BEEF);
        rd(32'h0000_0100);
        idle(1);

        // TX hold, overflow, then acceptance
        wr(32'h8000_0008, 32'h41);
        idle(5);
        wr(32'h8000_0008, 32'h42);
        rd(32'h8000_0000);
        idle(1);
        g_txr = 1'b1; idle(1); g_txr = 1'b0;
        idle(1);
        rd(32'h8000_0000);
        idle(1);

        // RX arrival, status and pop
        g_rxv = 1'b1; g_rxd = 8'h5A; idle(1); g_rxv = 1'b0;
        rd(32'h8000_0000);
        rd(32'h8000_0004);
        rd(32'h8000_0004);
        idle(1);

        // Counters after reset, then clear
        do_reset();
        for (int i = 0; i < 100; i++) begin
            g_ir = (i < 37);
            idle(1);
        end
        g_ir = 1'b0;
        rd(32'h8000_0010);
        rd(32'h8000_0014);
        wr(32'h8000_0018, 32'h0);
        rd(32'h8000_0010);
        rd(32'h8000_0014);
        idle(1);

        // Reset with TX and RX both occupied
        wr(32'h8000_0008, 32'h77);
        g_rxv = 1'b1; g_rxd = 8'hC3; idle(1); g_rxv = 1'b0;
        rd(32'h8000_0000);
        do_reset();
        rd(32'h8000_0000);
        idle(1);

        // Unmapped read, write to a read-only counter
        rd(32'h8000_0020);
        wr(32'h8000_0010, 32'h1234_5678);
        rd(32'h8000_0010);
        idle(1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            g_rst = ($urandom_range(0, 127) != 0);
            g_txr = ($urandom_range(0, 3) == 0);
            g_rxv = ($urandom_range(0, 4) == 0);
            g_rxd = 8'($urandom);
            g_ir  = $urandom_range(0, 1) == 1;
            kind  = $urandom_range(0, 4);
            we    = 4'($urandom_range(1, 15));
            if (kind <= 1) begin
                a = {1'b0, 15'($urandom), 12'h0, 4'($urandom)};
                a[13:4] = 10'($urandom_range(0, 3));
                if (kind == 0) step(1'b1, 4'h0, a, 32'h0);
                else           step(1'b1, we, a, $urandom);
            end else if (kind <= 3) begin
                a = {1'b1, 23'($urandom), 8'h0} | mm_offs[$urandom_range(0, 8)] | 32'($urandom_range(0, 3));
                if (kind == 2) step(1'b1, 4'h0, a, 32'h0);
                else           step(1'b1, we, a, $urandom);
            end else begin
                idle(1);
            end
        end
        g_rst = 1'b1; g_txr = 1'b0; g_rxv = 1'b0; g_ir = 1'b0;
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
